// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the two-requester FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BURST0 = 2'd1,
    BURST1 = 2'd2
  } arb_state_e;

  localparam int unsigned BURST_LEN_DEF = 4;

  // Narrowest counter that can hold the value n.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/arb_beat_counter.sv
// Beat counter for one arbitration tenure: clear, increment, last-beat flag.
module arb_beat_counter #(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CW        = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // High when the next accepted beat completes the tenure.
  assign last_o = (cnt_q == CW'(BURST_LEN - 1));

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Two-requester burst arbiter feeding one FIFO write port.
// Optional: ARB_HALF_FULL_THROTTLE_EN throttles requester 1 on half-full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BURST_LEN = BURST_LEN_DEF
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iReq0,
  input  logic             iReq1,
  input  logic [WIDTH-1:0] iData0,
  input  logic [WIDTH-1:0] iData1,
  output logic             oAck0,
  output logic             oAck1,
  input  logic             iFull,
  input  logic             iHalfFull,
  output logic             oWrEn,
  output logic [WIDTH-1:0] oWrData,
  output logic [1:0]       oGrant,
  output logic             oBusy
);

  localparam int unsigned CW = cnt_w(BURST_LEN);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       el0, el1;
  logic       thr_ok, hf_exit;
  logic       ack0, ack1;
  logic       beat_last;
  logic       cnt_clr;

`ifdef ARB_HALF_FULL_THROTTLE_EN
  assign thr_ok  = ~iHalfFull;
  assign hf_exit = iHalfFull;
`else
  logic hf_unused;
  assign hf_unused = iHalfFull;
  assign thr_ok    = 1'b1;
  assign hf_exit   = 1'b0;
`endif

  assign el0 = iReq0 & ~iFull;
  assign el1 = iReq1 & ~iFull & thr_ok;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    ack0    = 1'b0;
    ack1    = 1'b0;
    oGrant  = 2'b00;
    oWrData = '0;
    oBusy   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (el0 & el1) state_d = last_q ? BURST0 : BURST1;
        else if (el0)  state_d = BURST0;
        else if (el1)  state_d = BURST1;
      end
      BURST0: begin
        oGrant  = 2'b01;
        oBusy   = 1'b1;
        oWrData = iData0;
        ack0    = iReq0 & ~iFull & ~iRST;
        if (~iReq0 | (ack0 & beat_last)) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end
      BURST1: begin
        oGrant  = 2'b10;
        oBusy   = 1'b1;
        oWrData = iData1;
        ack1    = iReq1 & ~iFull & thr_ok & ~iRST;
        if (~iReq1 | hf_exit | (ack1 & beat_last)) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset cycle presents an idle port even if a burst was in flight.
    if (iRST) begin
      oGrant  = 2'b00;
      oWrData = '0;
      oBusy   = 1'b0;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign cnt_clr = (state_q == IDLE) | (state_d == IDLE);

  arb_beat_counter #(
    .BURST_LEN (BURST_LEN),
    .CW        (CW)
  ) u_cnt (
    .clk_i  (iCLK),
    .rst_i  (iRST),
    .clr_i  (cnt_clr),
    .inc_i  (ack0 | ack1),
    .last_o (beat_last)
  );

  assign oAck0 = ack0;
  assign oAck1 = ack1;
  assign oWrEn = ack0 | ack1;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random traffic.
module tb_fifo_wr_arbiter;

  localparam int W  = 8;
  localparam int BL = 4;
`ifdef ARB_HALF_FULL_THROTTLE_EN
  localparam bit THR = 1'b1;
`else
  localparam bit THR = 1'b0;
`endif

  logic         iCLK = 1'b0;
  logic         iRST, iReq0, iReq1, iFull, iHalfFull;
  logic [W-1:0] iData0, iData1;
  logic         oAck0, oAck1, oWrEn, oBusy;
  logic [W-1:0] oWrData;
  logic [1:0]   oGrant;

  fifo_wr_arbiter #(.WIDTH(W), .BURST_LEN(BL)) dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iReq0     (iReq0),
    .iReq1     (iReq1),
    .iData0    (iData0),
    .iData1    (iData1),
    .oAck0     (oAck0),
    .oAck1     (oAck1),
    .iFull     (iFull),
    .iHalfFull (iHalfFull),
    .oWrEn     (oWrEn),
    .oWrData   (oWrData),
    .oGrant    (oGrant),
    .oBusy     (oBusy)
  );

  always #5 iCLK = ~iCLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: owner 0=none, 1=requester0, 2=requester1.
  int m_own  = 0;
  int m_beat = 0;
  int m_last = 1;
  bit e_ack0, e_ack1;
  int wtr[$];
  int gtr[$];

  task automatic model_step();
    bit e0, e1, rq, ak;
    int n;
    if (iRST) begin
      m_own = 0; m_beat = 0; m_last = 1;
    end else if (m_own == 0) begin
      e0 = iReq0 && !iFull;
      e1 = iReq1 && !iFull && !(THR && iHalfFull);
      if (e0 && e1)  m_own = (m_last == 0) ? 2 : 1;
      else if (e0)   m_own = 1;
      else if (e1)   m_own = 2;
      m_beat = 0;
    end else begin
      n  = m_own - 1;
      rq = n ? iReq1 : iReq0;
      ak = n ? e_ack1 : e_ack0;
      if (ak) m_beat++;
      if (!rq || m_beat == BL || (THR && n == 1 && iHalfFull)) begin
        m_own = 0; m_last = n; m_beat = 0;
      end
    end
  endtask

  task automatic tick();
    int e_gr, e_wd;
    #1;
    e_ack0 = 0; e_ack1 = 0; e_gr = 0; e_wd = 0;
    if (!iRST && m_own == 1) begin
      e_ack0 = iReq0 && !iFull;
      e_gr = 1; e_wd = int'(iData0);
    end else if (!iRST && m_own == 2) begin
      e_ack1 = iReq1 && !iFull && !(THR && iHalfFull);
      e_gr = 2; e_wd = int'(iData1);
    end
    chk("ack0", 32'(oAck0), 32'(e_ack0));
    chk("ack1", 32'(oAck1), 32'(e_ack1));
    chk("wren", 32'(oWrEn), 32'(e_ack0 | e_ack1));
    chk("wdata", 32'(oWrData), 32'(e_wd));
    chk("grant", 32'(oGrant), 32'(e_gr));
    chk("busy", 32'(oBusy), 32'(e_gr != 0));
    wtr.push_back(oWrEn ? int'(oWrData) : 255);
    gtr.push_back(int'(oGrant));
    @(posedge iCLK);
    model_step();
    @(negedge iCLK);
  endtask

  task automatic do_reset();
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    wtr.delete();
    gtr.delete();
  endtask

  int ew33[10] = '{255, 1, 2, 3, 4, 255, 5, 6, 255, 255};
  int eg34[16] = '{0, 1, 1, 1, 1, 0, 2, 2, 2, 2, 0, 1, 1, 1, 1, 0};
  int ew35[9]  = '{0, 1, 1, 0, 0, 0, 1, 1, 0};
  int eg35[9]  = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
`ifdef ARB_HALF_FULL_THROTTLE_EN
  int eg36[11] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
`else
  int eg36[11] = '{0, 1, 1, 1, 1, 0, 2, 2, 2, 2, 0};
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int idx;
    iRST = 1'b1; iReq0 = 1'b1; iReq1 = 1'b1;
    iFull = 1'b0; iHalfFull = 1'b0;
    iData0 = 8'hA5; iData1 = 8'h5A;
    @(negedge iCLK);

    // Reset held with both requesting.
    repeat (2) tick();

    // Requester 0 alone, six items.
    iRST = 1'b0; iReq1 = 1'b0;
    wtr.delete();
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      iReq0  = (idx < 6);
      iData0 = W'(idx + 1);
      tick();
      if (e_ack0) idx++;
    end
    for (int c = 0; c < 10; c++) chk("r0_trace", 32'(wtr[c]), 32'(ew33[c]));

    // Both requesting continuously.
    do_reset();
    iReq0 = 1'b1; iReq1 = 1'b1;
    repeat (16) tick();
    for (int c = 0; c < 16; c++) chk("both_grant", 32'(gtr[c]), 32'(eg34[c]));

    // FIFO full for 3 cycles mid-burst.
    do_reset();
    iReq1 = 1'b0;
    for (int c = 0; c < 9; c++) begin
      iFull = (c >= 3 && c <= 5);
      tick();
    end
    for (int c = 0; c < 9; c++) begin
      chk("full_wr", 32'(wtr[c] != 255), 32'(ew35[c]));
      chk("full_gr", 32'(gtr[c]), 32'(eg35[c]));
    end
    iFull = 1'b0;

    // Half-full with both requesting.
    do_reset();
    iReq1 = 1'b1; iHalfFull = 1'b1;
    repeat (11) tick();
    for (int c = 0; c < 11; c++) chk("hf_grant", 32'(gtr[c]), 32'(eg36[c]));
    iHalfFull = 1'b0;

    // Reset after beat 2 of BURST1.
    do_reset();
    repeat (8) tick();
    chk("pre_rst_gr", 32'(gtr[7]), 32'd2);
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    gtr.delete();
    repeat (2) tick();
    chk("post_rst_gr", 32'(gtr[1]), 32'd1);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      iRST      = ($urandom % 64) == 0;
      iReq0     = ($urandom % 4) != 0;
      iReq1     = ($urandom % 4) != 0;
      iFull     = ($urandom % 5) == 0;
      iHalfFull = ($urandom % 3) == 0;
      iData0    = W'($urandom);
      iData1    = W'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width of each requester and of the FIFO write port.
REQ-002 The block SHALL have parameter BURST_LEN, default 4, giving the maximum beats granted to one requester per tenure (legal range 1..15).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port iCLK, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port iRST, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have ports iReq0 and iReq1, input, 1 bit each: requester n holds valid data.
REQ-007 The block SHALL have ports iData0 and iData1, input, WIDTH bits each: requester n write data.
REQ-008 The block SHALL have ports oAck0 and oAck1, output, 1 bit each: requester n beat accepted this cycle.
REQ-009 The block SHALL have port iFull, input, 1 bit: FIFO full flag.
REQ-010 The block SHALL have port iHalfFull, input, 1 bit: FIFO half-full flag.
REQ-011 The block SHALL have port oWrEn, output, 1 bit: FIFO write strobe, one beat per high cycle.
REQ-012 The block SHALL have port oWrData, output, WIDTH bits: FIFO write data.
REQ-013 The block SHALL have port oGrant, output, 2 bits: one-hot current owner, 2'b00 when idle.
REQ-014 The block SHALL have port oBusy, output, 1 bit: asserted whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, BURST0 and BURST1.
REQ-016 IDLE SHALL move to BURSTn when requester n is eligible (iReqn=1, iFull=0); if both are eligible, the requester not served last wins.
REQ-017 oAckn SHALL be combinational and equal state==BURSTn & iReqn & !iFull.
REQ-018 oWrEn SHALL equal oAck0|oAck1, with zero latency from acceptance to write strobe.
REQ-019 oWrData SHALL equal iDatan of the current owner, and SHALL be 0 in IDLE.
REQ-020 The beat counter SHALL be cleared on entry to BURSTn and SHALL increment by 1 on each ack; its width SHALL be the minimum that holds BURST_LEN.
REQ-021 BURSTn SHALL move to IDLE after the ack that makes the beat count reach BURST_LEN, or in any cycle where iReqn=0.
REQ-022 While iFull=1 in BURSTn with iReqn=1, the FSM SHALL hold state, issue no ack, and leave the beat count unchanged.
REQ-023 The last-served pointer SHALL update to n on every BURSTn->IDLE transition.
REQ-024 One IDLE cycle (bubble) SHALL occur between consecutive tenures, including back-to-back tenures of the same requester.
REQ-025 A requester SHALL never receive an ack in IDLE or in the other requester's burst.

Reset
REQ-026 While iRST=1: state SHALL be IDLE, beat count 0, last-served pointer 1 (requester 0 wins first), and oAck0, oAck1, oWrEn, oGrant, oBusy and oWrData SHALL all be 0.
REQ-027 Reset asserted mid-burst SHALL abort the burst with no ack in the reset cycle and no partial-state carry-over.

Configuration
REQ-028 With macro ARB_HALF_FULL_THROTTLE_EN defined, requester 1 SHALL be ineligible in IDLE while iHalfFull=1; oAck1 SHALL additionally be gated by !iHalfFull; and BURST1 SHALL move to IDLE in any cycle where iHalfFull=1.
REQ-029 With ARB_HALF_FULL_THROTTLE_EN undefined, iHalfFull SHALL be ignored and both requesters SHALL be treated symmetrically.

Structure
REQ-030 Shared package fifo_arb_pkg SHALL hold the state encoding constants (IDLE, BURST0, BURST1) and the default BURST_LEN.
REQ-031 The beat counter SHALL be a sub-module named arb_beat_counter (clear, increment, terminal-count output); all other logic SHALL be inline.

Verification
REQ-032 The bench SHALL hold iRST=1 for 2 cycles with both requests high -> oWrEn=0, oAck0=oAck1=0, oGrant=00, oBusy=0 throughout.
REQ-033 The bench SHALL drive only iReq0 with data 01..06 -> writes 01,02,03,04 on consecutive cycles, 1 bubble, then 05,06, then IDLE.
REQ-034 The bench SHALL hold both requests continuously from reset -> grant pattern 0x4, bubble, 1x4, bubble, 0x4, and oGrant is never 11.
REQ-035 The bench SHALL raise iFull for 3 cycles after beat 2 of BURST0 -> no oWrEn for those 3 cycles, state stays BURST0, then beats 3 and 4 are written and the burst ends.
REQ-036 The bench SHALL run with the macro defined, iHalfFull=1 and both requesting -> only requester 0 is served; with the macro undefined -> alternating tenures.
REQ-037 The bench SHALL assert iRST after beat 2 of BURST1 -> after release with both requesting, requester 0 is granted first.
